fb_read_scheduler: RTL and testbench

//  Owns the single read port of the camera frame-buffer BRAM (8-bit pixels).
//  - Generates scaled display read addresses from hcount/vcount.
//  - Lends the port to an auxiliary requester (lightboard draw/analysis logic) outside the active window.
//  - Returns pixel and aux data with delayed hcount/vcount, so the downstream colour expander
//    (8-bit to 12-bit) and the output mux stay aligned.

---
 rtl/fb_read_scheduler.sv | 144 ++++++++++++++
 tb/tb_fb_read_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fb_read_scheduler.sv
// fb_read_scheduler: owns the frame-buffer BRAM read port, interleaving scaled display reads with aux reads.
// Optional feature macro FB_SCHED_STATS_EN adds aux grant/stall counters.
module fb_read_scheduler #(
    parameter int SRC_W       = 320,
    parameter int SRC_H       = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int ACTIVE_H    = 640,
    parameter int ACTIVE_V    = 480,
    parameter int BRAM_LAT    = 2,
    parameter int ADDR_W      = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              aux_req_in,
    input  logic [ADDR_W-1:0] aux_addr_in,
    output logic              aux_grant_out,
    output logic              aux_valid_out,
    output logic [7:0]        aux_data_out,
`ifdef FB_SCHED_STATS_EN
    output logic [15:0]       aux_grant_cnt_out,
    output logic [15:0]       aux_stall_cnt_out,
`endif
    output logic [ADDR_W-1:0] bram_addr_out,
    input  logic [7:0]        bram_data_in,
    output logic [7:0]        pix_out,
    output logic              pix_valid_out,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic              frame_start_out
);
    // Window is clamped to the scaled frame-buffer extent so a mismatched ACTIVE_* cannot over-read.
    localparam int H_LIMIT = (ACTIVE_H < (SRC_W << SCALE_SHIFT)) ? ACTIVE_H : (SRC_W << SCALE_SHIFT);
    localparam int V_LIMIT = (ACTIVE_V < (SRC_H << SCALE_SHIFT)) ? ACTIVE_V : (SRC_H << SCALE_SHIFT);
    localparam logic [10:0]       H_END     = 11'(H_LIMIT);
    localparam logic [9:0]        V_END     = 10'(V_LIMIT);
    localparam logic [9:0]        V_PHASE   = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SRC_W);
    localparam int unsigned       DEPTH     = unsigned'(BRAM_LAT + 1);

    typedef enum logic {S_BLANK, S_ACTIVE} state_t;

    typedef struct packed {
        logic        is_aux;
        logic        win;
        logic [10:0] h;
        logic [9:0]  v;
        logic        fs;
    } tag_t;

    state_t            state, next_state;
    logic              win, origin;
    logic [ADDR_W-1:0] line_base, base_now, disp_addr;
    tag_t              tag_in, tag_out;
    tag_t              tag_pipe [DEPTH];

    always_comb begin
        win    = (hcount_in < H_END) && (vcount_in < V_END);
        origin = (hcount_in == '0) && (vcount_in == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= S_BLANK;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_BLANK:  if (win)  next_state = S_ACTIVE;
            S_ACTIVE: if (!win) next_state = S_BLANK;
        endcase
    end

    // Decoded from next_state so the display claims the port on the very cycle win rises.
    always_comb begin
        aux_grant_out = 1'b0;
        if (rst_n_in && next_state == S_BLANK) aux_grant_out = aux_req_in;
    end

    always_comb begin
        base_now  = origin ? '0 : line_base;
        disp_addr = base_now + ADDR_W'(hcount_in >> SCALE_SHIFT);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || origin) begin
            line_base <= '0;
        end else if (hcount_in == H_END && vcount_in < V_END &&
                     (vcount_in & V_PHASE) == V_PHASE) begin
            line_base <= line_base + LINE_STEP;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)          bram_addr_out <= '0;
        else if (win)           bram_addr_out <= disp_addr;
        else if (aux_grant_out) bram_addr_out <= aux_addr_in;
    end

    always_comb begin
        tag_in.is_aux = aux_grant_out;
        tag_in.win    = win;
        tag_in.h      = hcount_in;
        tag_in.v      = vcount_in;
        tag_in.fs     = origin;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        tag_out         = tag_pipe[DEPTH-1];
        pix_valid_out   = tag_out.win;
        pix_out         = tag_out.win ? bram_data_in : '0;
        aux_valid_out   = tag_out.is_aux;
        aux_data_out    = tag_out.is_aux ? bram_data_in : '0;
        hcount_out      = tag_out.h;
        vcount_out      = tag_out.v;
        frame_start_out = tag_out.fs;
    end

`ifdef FB_SCHED_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || frame_start_out) begin
            aux_grant_cnt_out <= '0;
            aux_stall_cnt_out <= '0;
        end else begin
            if (aux_grant_out && aux_grant_cnt_out != '1)
                aux_grant_cnt_out <= aux_grant_cnt_out + 16'd1;
            if (aux_req_in && !aux_grant_out && aux_stall_cnt_out != '1)
                aux_stall_cnt_out <= aux_stall_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Scoreboard bench for fb_read_scheduler: compressed raster (a few hcount segments per line),
// a latency-2 BRAM model, aux requests in blanking, and a mid-frame reset.
module tb_fb_read_scheduler;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_grant, aux_valid;
    logic [7:0]        aux_data;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_data, d1, d2;
    logic [7:0]        pix;
    logic              pix_valid, frame_start;
    logic [10:0]       hcount_o;
    logic [9:0]        vcount_o;
`ifdef FB_SCHED_STATS_EN
    logic [15:0]       grant_cnt, stall_cnt;
    logic [15:0]       m_gcnt = '0, m_scnt = '0;
`endif

    always #5 clk = ~clk;

    fb_read_scheduler #(
        .SRC_W(320), .SRC_H(240), .SCALE_SHIFT(1), .ACTIVE_H(640),
        .ACTIVE_V(480), .BRAM_LAT(2), .ADDR_W(ADDR_W)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .hcount_in(hcount),
        .vcount_in(vcount),
        .aux_req_in(aux_req),
        .aux_addr_in(aux_addr),
        .aux_grant_out(aux_grant),
        .aux_valid_out(aux_valid),
        .aux_data_out(aux_data),
`ifdef FB_SCHED_STATS_EN
        .aux_grant_cnt_out(grant_cnt),
        .aux_stall_cnt_out(stall_cnt),
`endif
        .bram_addr_out(bram_addr),
        .bram_data_in(bram_data),
        .pix_out(pix),
        .pix_valid_out(pix_valid),
        .hcount_out(hcount_o),
        .vcount_out(vcount_o),
        .frame_start_out(frame_start)
    );

    function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[16], 7'd0} ^ 8'h5A;
    endfunction

    // Two-cycle read latency BRAM
    always @(posedge clk) begin
        d1 <= mem_byte(bram_addr);
        d2 <= d1;
    end
    assign bram_data = d2;

    typedef struct {
        logic              win, aux, fs, chk;
        logic [10:0]       h;
        logic [9:0]        v;
        logic [7:0]        data;
    } exp_t;

    exp_t              q[$];
    int                errors = 0, checks = 0, frame_no = 0;
    logic              addr_known = 1'b0, addr_chk = 1'b0;
    logic [ADDR_W-1:0] addr_exp = '0;
    int                prev_h = -1, prev_v = -1;
    logic              prev_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input int h, input int v, input logic req,
                         input logic [ADDR_W-1:0] a, input logic rst);
        exp_t              e, o, z;
        logic              win, g, fs_now;
        logic [ADDR_W-1:0] da;
        hcount   = 11'(h);
        vcount   = 10'(v);
        aux_req  = req;
        aux_addr = a;
        rst_n    = rst;
        win = (h < 640) && (v < 480);
        g   = rst && !win && req;
        da  = ADDR_W'((v >> 1) * 320 + (h >> 1));
        if (rst && h == 0 && v == 0) addr_known = 1'b1;

        e.win = win; e.aux = g; e.fs = (h == 0 && v == 0); e.chk = addr_known;
        e.h = 11'(h); e.v = 10'(v); e.data = g ? mem_byte(a) : mem_byte(da);

        @(negedge clk);
        check("grant", aux_grant, g);
        if (addr_chk) check("bram_addr", bram_addr, addr_exp);
        if (prev_known && prev_h == 5 && prev_v == 3) check("addr_5_3", bram_addr, 322);
        if (prev_known && prev_h == 0 && prev_v == 479) check("addr_0_479", bram_addr, 76480);

        q.push_back(e);
        fs_now = 1'b0;
        if (q.size() > 3) begin
            o = q.pop_front();
            fs_now = o.fs;
            check("pix_valid", pix_valid, o.win);
            check("hcount_out", hcount_o, o.h);
            check("vcount_out", vcount_o, o.v);
            check("frame_start", frame_start, o.fs);
            check("aux_valid", aux_valid, o.aux);
            check("aux_data", aux_data, o.aux ? o.data : 8'h00);
            if (!o.win || o.chk) check("pix", pix, o.win ? o.data : 8'h00);
        end

`ifdef FB_SCHED_STATS_EN
        check("grant_cnt", grant_cnt, m_gcnt);
        check("stall_cnt", stall_cnt, m_scnt);
        if (fs_now && frame_no == 1) begin
            check("grant_cnt_frame0", grant_cnt, 5);
            check("stall_cnt_frame0", stall_cnt, 7);
        end
        if (!rst || fs_now) begin
            m_gcnt = '0;
            m_scnt = '0;
        end else begin
            if (g && m_gcnt != 16'hFFFF) m_gcnt++;
            if (req && !g && m_scnt != 16'hFFFF) m_scnt++;
        end
`endif

        if (!rst) begin
            // in-flight reads are dropped; the three cycles after reset show a flushed pipe
            q.delete();
            z.win = 0; z.aux = 0; z.fs = 0; z.chk = 1; z.h = '0; z.v = '0; z.data = '0;
            repeat (3) q.push_back(z);
            addr_known = 1'b0;
            addr_chk = 1'b1; addr_exp = '0;
        end else if (g) begin
            addr_chk = 1'b1; addr_exp = a;
        end else if (win && addr_known) begin
            addr_chk = 1'b1; addr_exp = da;
        end else begin
            addr_chk = 1'b0;
        end
        prev_h = h; prev_v = v; prev_known = addr_known && rst;

        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int f, input int h, input int v);
        logic              req, rst;
        logic [ADDR_W-1:0] a;
        req = 1'b0; a = '0; rst = 1'b1;
        if (f == 0 && v == 0 && h >= 634 && h <= 644) begin req = 1'b1; a = ADDR_W'(1000 + h); end
        if (f == 0 && v == 12 && h == 0)   begin req = 1'b1; a = 17'h00555; end
        if (f == 1 && v == 10 && h == 700) begin req = 1'b1; a = 17'h01234; end
        if (f == 1 && v == 11 && h == 701) begin req = 1'b1; a = 17'h1FFFF; end
        if (f == 1 && v == 481 && (h == 3 || h == 4)) begin req = 1'b1; a = ADDR_W'(256 + h); end
        if (f == 1 && v == 200 && h == 300) rst = 1'b0;
        cycle(h, v, req, a, rst);
    endtask

    task automatic run_line(input int f, input int v);
        for (int h = 0; h < 8; h++) drive(f, h, v);
        if (v == 200) for (int h = 298; h <= 302; h++) drive(f, h, v);
        for (int h = 630; h <= 650; h++) drive(f, h, v);
        for (int h = 698; h <= 701; h++) drive(f, h, v);
    endtask

    initial begin
        rst_n = 1'b0; hcount = '0; vcount = '0; aux_req = 1'b0; aux_addr = '0;
        @(posedge clk);
        #1;
        repeat (3) cycle(700, 490, 1'b0, '0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            frame_no = f;
            for (int v = 0; v <= ((f == 2) ? 4 : 481); v++) run_line(f, v);
        end
        repeat (4) cycle(700, 5, 1'b0, '0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
